// File: rtl/acc_shift_executor_pkg.sv
// Shared timing constants, step counter width and FSM state encoding
// for the accumulator shift executor and its digit timer.
package acc_shift_executor_pkg;

    localparam int MC_LEN_DEF = 18;
    localparam int DIGIT_D0   = 0;
    localparam int DIGIT_D1   = 1;
    localparam int STEP_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/acc_shift_executor_if.sv
// Control, data and timing signals between the shift-control CCU side and the executor.
// The master drives the orders and load data; the slave returns acc, timing and status.
interface acc_shift_executor_if
    import acc_shift_executor_pkg::*;
#(
    parameter int ACC_WIDTH = 71
);

    logic                 g5;
    logic                 ep2;
    logic                 reset_shift_ff;
    logic                 shift_left;
    logic                 acc_load;
    logic [ACC_WIDTH-1:0] acc_din;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ev_d0;
    logic                 ev_d1;
    logic                 dy;
    logic                 busy;
    logic                 shift_done;
    logic [STEP_W-1:0]    step_cnt;
    logic                 shift_err;
    logic                 ovf;

    modport master (
        output g5, ep2, reset_shift_ff, shift_left, acc_load, acc_din,
        input  acc, ev_d0, ev_d1, dy, busy, shift_done, step_cnt, shift_err, ovf
    );

    modport slave (
        input  g5, ep2, reset_shift_ff, shift_left, acc_load, acc_din,
        output acc, ev_d0, ev_d1, dy, busy, shift_done, step_cnt, shift_err, ovf
    );

endinterface

// File: rtl/acc_shift_executor_digit_timer.sv
// Free-running digit counter (0..MC_LEN-1) with ev_d0/ev_d1 decodes and the dy
// order-position match; all decodes are combinational off the counter register.
module acc_shift_executor_digit_timer
    import acc_shift_executor_pkg::*;
#(
    parameter int MC_LEN = MC_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dy_en_i,
    input  logic [STEP_W-1:0] pos_i,
    output logic              last_o,
    output logic              ev_d0_o,
    output logic              ev_d1_o,
    output logic              dy_o
);

    localparam int DW = $clog2(MC_LEN);
    localparam int CW = max_int(DW, STEP_W);

    logic [DW-1:0] dcnt_q, dcnt_d;

    assign last_o = (dcnt_q == DW'(MC_LEN - 1));
    assign dcnt_d = last_o ? '0 : dcnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    // Timing outputs are held low while reset is asserted, even though the count sits at 0.
    assign ev_d0_o = !rst && (dcnt_q == DW'(DIGIT_D0));
    assign ev_d1_o = !rst && (dcnt_q == DW'(DIGIT_D1));

    // Position 0 never marks a completed step, so the entry minor cycle stays silent.
    assign dy_o = !rst && dy_en_i && (pos_i != '0) && (CW'(dcnt_q) == CW'(pos_i));

endmodule

// File: rtl/acc_shift_executor.sv
// R/L shift executor: one accumulator digit shift per minor cycle while g5 gates SHIFT;
// first shift lands one minor cycle after start, no backpressure. EDSAC_SHIFT_OVF_EN adds L-overflow flag.
module acc_shift_executor
    import acc_shift_executor_pkg::*;
#(
    parameter int ACC_WIDTH  = 71,
    parameter int MC_LEN     = MC_LEN_DEF,
    parameter int ORDER_BITS = 10
) (
    input logic                 clk,
    input logic                 rst,
    acc_shift_executor_if.slave bus
);

    state_t               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, shifted;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 do_shift;
    logic                 at_d0, at_last;

    acc_shift_executor_digit_timer #(
        .MC_LEN (MC_LEN)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .dy_en_i (state_q == ST_SHIFT),
        .pos_i   (step_q),
        .last_o  (at_last),
        .ev_d0_o (at_d0),
        .ev_d1_o (bus.ev_d1),
        .dy_o    (bus.dy)
    );

    assign shifted = dir_q ? {acc_q[ACC_WIDTH-2:0], 1'b0}
                           : {acc_q[ACC_WIDTH-1], acc_q[ACC_WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        step_d   = step_q;
        acc_d    = acc_q;
        err_d    = err_q;
        done_d   = 1'b0;
        do_shift = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.g5 && at_d0) begin
                    state_d = ST_SHIFT;
                    dir_d   = bus.shift_left;
                    step_d  = '0;
                end
            end
            ST_SHIFT: begin
                // Priority: load abort, then termination, then lost gate, then the step boundary.
                if (bus.acc_load) begin
                    state_d = ST_IDLE;
                end else if (bus.ep2 || bus.reset_shift_ff) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!bus.g5) begin
                    state_d = ST_IDLE;
                end else if (at_last) begin
                    if (step_q == STEP_W'(ORDER_BITS)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        do_shift = 1'b1;
                        step_d   = step_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.g5) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_shift) begin
            acc_d = shifted;
        end
        if (bus.acc_load) begin
            acc_d = bus.acc_din;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            step_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef EDSAC_SHIFT_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (bus.acc_load) begin
            ovf_d = 1'b0;
        end else if (do_shift && dir_q && (shifted[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.acc        = acc_q;
    assign bus.ev_d0      = at_d0;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.shift_done = done_q;
    assign bus.step_cnt   = step_q;
    assign bus.shift_err  = err_q;

endmodule

// File: tb/tb_acc_shift_executor.sv
// Bench for acc_shift_executor: vector table, hand-written corner sequences and
// randomized orders checked against a shift-count reference model.
module tb_acc_shift_executor;
    import acc_shift_executor_pkg::*;

    localparam int W          = 71;
    localparam int MC         = 18;
    localparam int ORDER_BITS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    acc_shift_executor_if #(.ACC_WIDTH(W)) bus ();

    acc_shift_executor #(
        .ACC_WIDTH  (W),
        .MC_LEN     (MC),
        .ORDER_BITS (ORDER_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] init;
        bit           left;
        int           ep2_at;
        bit           use_rsf;
        logic [W-1:0] exp_acc;
        int           exp_steps;
        bit           exp_err;
        bit           exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout got no event want event", nm);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_acc"},        bus.acc, '0);
        chk({tag, "_busy"},       W'(bus.busy), '0);
        chk({tag, "_step_cnt"},   W'(bus.step_cnt), '0);
        chk({tag, "_ev_d0"},      W'(bus.ev_d0), '0);
        chk({tag, "_ev_d1"},      W'(bus.ev_d1), '0);
        chk({tag, "_dy"},         W'(bus.dy), '0);
        chk({tag, "_shift_done"}, W'(bus.shift_done), '0);
        chk({tag, "_shift_err"},  W'(bus.shift_err), '0);
        chk({tag, "_ovf"},        W'(bus.ovf), '0);
    endtask

    task automatic load(input logic [W-1:0] v);
        @(negedge clk);
        bus.acc_din  = v;
        bus.acc_load = 1'b1;
        @(negedge clk);
        bus.acc_load = 1'b0;
    endtask

    task automatic wait_d0(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * MC && !ok; i++) begin
            @(negedge clk);
            if (bus.ev_d0) ok = 1'b1;
        end
        if (!ok) timeout_fail({tag, "_wait_d0"});
    endtask

    // Shift count n = termination step, or ORDER_BITS when the order runs to the limit.
    // ovf: some L step changes the sign, i.e. the top n+1 bits of the start value disagree.
    task automatic model(input logic [W-1:0] init, input bit left, input int ep2_at,
                         output logic [W-1:0] acc, output int steps, output bit err, output bit ov);
        int n;
        n     = (ep2_at == 0) ? ORDER_BITS : ep2_at;
        steps = n;
        err   = (ep2_at == 0);
        ov    = 1'b0;
        if (left) begin
            acc = init << n;
            for (int i = 0; i < n; i++) begin
                if (init[W-1-i] != init[W-2-i]) ov = 1'b1;
            end
        end else begin
            acc = $signed(init) >>> n;
        end
    endtask

    task automatic run_order(input string tag, input logic [W-1:0] init, input bit left,
                             input int ep2_at, input bit use_rsf, input logic [W-1:0] exp_acc,
                             input int exp_steps, input bit exp_err, input bit exp_ovf);
        int  ndy   = 0;
        int  dones = 0;
        int  digit = 0;
        bit  fin   = 1'b0;
        bit  ok;
        bit  want_ovf;
`ifdef EDSAC_SHIFT_OVF_EN
        want_ovf = exp_ovf;
`else
        want_ovf = 1'b0;
`endif
        load(init);
        wait_d0(tag, ok);
        bus.shift_left = left;
        bus.g5         = 1'b1;
        for (int cyc = 1; cyc <= 12 * MC && !fin; cyc++) begin
            @(negedge clk);
            bus.ep2            = 1'b0;
            bus.reset_shift_ff = 1'b0;
            digit = bus.ev_d0 ? 0 : digit + 1;
            if (bus.shift_done) dones++;
            if (bus.dy) begin
                ndy++;
                chk({tag, "_dy_pos"}, W'(digit), W'(ndy));
                if (ndy == ep2_at) begin
                    if (use_rsf) bus.reset_shift_ff = 1'b1;
                    else         bus.ep2 = 1'b1;
                end
            end
            if (!bus.busy && cyc > 1) fin = 1'b1;
        end
        if (!fin) timeout_fail({tag, "_busy_drop"});
        bus.g5 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.shift_done) dones++;
        end
        chk({tag, "_acc"},       bus.acc, exp_acc);
        chk({tag, "_step_cnt"},  W'(bus.step_cnt), W'(exp_steps));
        chk({tag, "_dy_count"},  W'(ndy), W'(exp_steps));
        chk({tag, "_done_cnt"},  W'(dones), W'(1));
        chk({tag, "_shift_err"}, W'(bus.shift_err), W'(exp_err));
        chk({tag, "_ovf"},       W'(bus.ovf), W'(want_ovf));
        chk({tag, "_idle"},      W'(bus.busy), '0);
    endtask

    initial begin
        logic [W-1:0] r_init, m_acc;
        int           r_ep2, m_steps, dones, seen;
        bit           r_left, m_err, m_ov, ok, fin;

        bus.g5 = 1'b0; bus.ep2 = 1'b0; bus.reset_shift_ff = 1'b0;
        bus.shift_left = 1'b0; bus.acc_load = 1'b0; bus.acc_din = '0;

        vecs[0] = '{71'h1, 1'b1, 3, 1'b0, 71'h8, 3, 1'b0, 1'b0};
        vecs[1] = '{71'h40_0000_0000_0000_0005, 1'b0, 2, 1'b0, 71'h70_0000_0000_0000_0001, 2, 1'b0, 1'b0};
        vecs[2] = '{71'h3, 1'b1, 0, 1'b0, 71'hC00, 10, 1'b1, 1'b0};
        vecs[3] = '{71'h100, 1'b0, 5, 1'b1, 71'h8, 5, 1'b0, 1'b0};
        vecs[4] = '{71'h20_0000_0000_0000_0000, 1'b1, 1, 1'b0, 71'h40_0000_0000_0000_0000, 1, 1'b0, 1'b1};
        vecs[5] = '{71'h7, 1'b1, 10, 1'b0, 71'h1C00, 10, 1'b0, 1'b0};

        // Reset state and digit counter start-up.
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        #1;
        chk("ev_d0_first", W'(bus.ev_d0), W'(1));
        @(negedge clk);
        chk("ev_d1_second", W'(bus.ev_d1), W'(1));
        chk("ev_d0_second", W'(bus.ev_d0), '0);

        for (int i = 0; i < 6; i++) begin
            run_order($sformatf("vec%0d", i), vecs[i].init, vecs[i].left, vecs[i].ep2_at,
                      vecs[i].use_rsf, vecs[i].exp_acc, vecs[i].exp_steps, vecs[i].exp_err,
                      vecs[i].exp_ovf);
        end

        // ep2 on the first step boundary: termination wins, nothing shifts.
        load(71'h5);
        wait_d0("ep2_edge", ok);
        bus.shift_left = 1'b1;
        bus.g5 = 1'b1;
        repeat (MC - 1) @(negedge clk);
        bus.ep2 = 1'b1;
        @(negedge clk);
        bus.ep2 = 1'b0;
        chk("ep2_edge_acc", bus.acc, 71'h5);
        chk("ep2_edge_step_cnt", W'(bus.step_cnt), '0);
        chk("ep2_edge_done", W'(bus.shift_done), W'(1));
        chk("ep2_edge_busy", W'(bus.busy), '0);
        bus.g5 = 1'b0;
        @(negedge clk);

        // Step limit, DONE holds while g5 stays high, restart, then load abort.
        load(71'h1);
        wait_d0("limit", ok);
        bus.shift_left = 1'b1;
        bus.g5 = 1'b1;
        fin = 1'b0;
        for (int cyc = 1; cyc <= 12 * MC && !fin; cyc++) begin
            @(negedge clk);
            if (!bus.busy && cyc > 1) fin = 1'b1;
        end
        if (!fin) timeout_fail("limit_busy_drop");
        chk("limit_err", W'(bus.shift_err), W'(1));
        chk("limit_acc", bus.acc, 71'h400);
        seen = 0;
        repeat (2 * MC) begin
            @(negedge clk);
            if (bus.busy) seen++;
        end
        chk("done_hold_busy", W'(seen), '0);
        bus.g5 = 1'b0;
        @(negedge clk);
        bus.g5 = 1'b1;
        fin = 1'b0;
        for (int cyc = 0; cyc < 2 * MC && !fin; cyc++) begin
            @(negedge clk);
            if (bus.busy) fin = 1'b1;
        end
        chk("restart_busy", W'(fin), W'(1));
        repeat (5) @(negedge clk);
        bus.acc_din  = 71'h1234;
        bus.acc_load = 1'b1;
        bus.g5       = 1'b0;
        dones = 0;
        @(negedge clk);
        bus.acc_load = 1'b0;
        if (bus.shift_done) dones++;
        chk("abort_acc", bus.acc, 71'h1234);
        chk("abort_busy", W'(bus.busy), '0);
        chk("abort_err_clr", W'(bus.shift_err), '0);
        repeat (3) begin
            @(negedge clk);
            if (bus.shift_done) dones++;
        end
        chk("abort_no_done", W'(dones), '0);

        // g5 lost mid-order: back to IDLE, one shift kept, no shift_done.
        load(71'h55);
        wait_d0("g5_drop", ok);
        bus.shift_left = 1'b0;
        bus.g5 = 1'b1;
        repeat (MC + 5) @(negedge clk);
        bus.g5 = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.shift_done) dones++;
        end
        chk("g5_drop_busy", W'(bus.busy), '0);
        chk("g5_drop_done", W'(dones), '0);
        chk("g5_drop_acc", bus.acc, 71'h2A);

        // Reset in the middle of an order.
        load(71'h40_0000_0000_0000_00FF);
        wait_d0("rst_mid", ok);
        bus.shift_left = 1'b1;
        bus.g5 = 1'b1;
        repeat (MC + 7) @(negedge clk);
        rst = 1'b1;
        bus.g5 = 1'b0;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0;
        @(negedge clk);

        // Randomized orders against the reference model.
        for (int i = 0; i < 12; i++) begin
            r_init = W'({$urandom(), $urandom(), $urandom()});
            r_left = 1'($urandom_range(0, 1));
            r_ep2  = $urandom_range(0, ORDER_BITS);
            model(r_init, r_left, r_ep2, m_acc, m_steps, m_err, m_ov);
            run_order($sformatf("rnd%0d", i), r_init, r_left, r_ep2, 1'($urandom_range(0, 1)),
                      m_acc, m_steps, m_err, m_ov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
